rr_burst_arbiter: RTL and testbench
===================================

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 Parameter: BURST_MAX, default 4, maximum consecutive grant cycles per ownership; legal range 1..15; used only when ARB_BURST_LIMIT_EN is defined.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising clk).
REQ-004 Port: req3, req2, req1, req0  input  1 each  level request from requester 3..0; held high while access is wanted.
REQ-005 Port: gnt3, gnt2, gnt1, gnt0  output  1 each  registered grant; at most one high in any cycle.
REQ-006 Port: busy  output  1  registered; high whenever any gnt is high.
REQ-007 Port: owner  output  2  registered index of the granted requester; valid only when busy=1, holds its last value otherwise.

Function
REQ-008 The FSM SHALL have two states: IDLE (no grant) and GRANT (one grant held); the state SHALL change only on rising clk.
REQ-009 A 2-bit pointer ptr SHALL hold the highest-priority index; the search order is ptr, ptr+1, ptr+2, ptr+3, each mod 4.
REQ-010 IDLE: if any req is 1 at an edge, the first requester in search order SHALL be granted at that edge; the state goes to GRANT and ptr is set to (granted index + 1) mod 4.
REQ-011 IDLE with all req=0: all outputs and ptr SHALL hold.
REQ-012 Latency: gnt SHALL rise on the first rising edge at which the corresponding req is sampled high and selected; no combinational req-to-gnt path.
REQ-013 GRANT: while req[owner]=1 and no burst limit is reached, the grant, owner, and ptr SHALL hold.
REQ-014 GRANT, req[owner]=0 at an edge: if any other req=1, the next requester in search order SHALL be granted at that same edge, with no idle cycle; otherwise all gnt SHALL clear and the state goes to IDLE.
REQ-015 A requester dropping req SHALL lose its grant on the next edge; a glitch-free one-hot gnt SHALL be maintained during the handover.
REQ-016 Simultaneous requests SHALL be resolved by ptr order only; after each grant, the granted requester becomes lowest priority.
REQ-017 ptr wrap-around from 3 to 0 SHALL follow mod-4 arithmetic.

Reset
REQ-018 When rst=0 at an edge, the block SHALL set gnt3..gnt0=0, busy=0, owner=0, ptr=0 (req0 highest priority), burst count=0, and state=IDLE.
REQ-019 Reset asserted while in GRANT SHALL drop the grant at that edge, regardless of req.
REQ-020 In the first edge with rst=1, the block SHALL arbitrate normally per REQ-010.

Configuration
REQ-021 Macro ARB_BURST_LIMIT_EN defined: a 4-bit counter SHALL load 1 on each new grant and increment each held cycle.
REQ-022 With ARB_BURST_LIMIT_EN, when the counter equals BURST_MAX and req[owner]=1, the block SHALL rearbitrate at that edge using the current ptr order.
REQ-023 On a burst-limit rearbitration with no other requester pending, the same owner SHALL be re-granted: gnt stays high, the counter reloads 1, and ptr is updated per REQ-010.
REQ-024 Macro ARB_BURST_LIMIT_EN undefined: no counter SHALL exist, and ownership SHALL end only via REQ-014 or reset.

Verification
REQ-025 Reset then single request: rst=0 for 5 edges then 1; req0=1 for 3 cycles -> gnt0=1 one edge after req0 is sampled, busy=1, owner=0; gnt0=0 one edge after req0 drops.
REQ-026 Simultaneous requests: after reset, req0=req1=1 -> gnt0 first; when req0 drops, gnt1 rises the same edge with no gap; owner goes 0 then 1.
REQ-027 Fairness: all req held high, ARB_BURST_LIMIT_EN, BURST_MAX=4 -> grant order 0,1,2,3,0 with each gnt high exactly 4 cycles; at most one gnt high in any cycle.
REQ-028 Sole requester at limit: ARB_BURST_LIMIT_EN, req2 only, held 10 cycles -> gnt2 continuously high for 10 cycles, counter reloads at 4 and 8.
REQ-029 Macro undefined: req1 held 20 cycles with req3=1 -> gnt1 held for all 20 cycles; gnt3 rises the edge req1 is sampled low.
REQ-030 Reset mid-grant: rst=0 while gnt2=1 -> all gnt=0 and busy=0 at that edge; after release with req2=req0=1, gnt0 granted first because ptr=0.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grants and handover without an idle cycle.
// Optional burst limit: define ARB_BURST_LIMIT_EN to force rearbitration after BURST_MAX held cycles.
module rr_burst_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req3,
  input  logic       req2,
  input  logic       req1,
  input  logic       req0,
  output logic       gnt3,
  output logic       gnt2,
  output logic       gnt1,
  output logic       gnt0,
  output logic       busy,
  output logic [1:0] owner
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] owner_q;
  logic [3:0] gnt_q;
  logic       busy_q;
  logic [3:0] req_v;
  logic       pick_vld;
  logic [1:0] pick_idx;
  logic       own_req;
  logic       limit_hit;
  logic       do_grant;
  logic       do_release;

  assign req_v   = {req3, req2, req1, req0};
  assign own_req = req_v[owner_q];

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    logic [1:0] idx;
    idx      = '0;
    pick_vld = 1'b0;
    pick_idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_v[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  logic [3:0] cnt;
  assign limit_hit = (cnt == 4'(BURST_MAX));
`else
  assign limit_hit = 1'b0;
`endif

  // In GRANT the owner's own req is never picked when it has dropped, so a
  // pick always means a different requester; at the limit it may re-pick the owner.
  always_comb begin
    do_grant   = 1'b0;
    do_release = 1'b0;
    if (state == IDLE) begin
      do_grant = pick_vld;
    end else if (!own_req || limit_hit) begin
      do_grant   = pick_vld;
      do_release = !pick_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (do_grant) begin
      state   <= GRANT;
      ptr     <= pick_idx + 2'd1;
      owner_q <= pick_idx;
      gnt_q   <= 4'b0001 << pick_idx;
      busy_q  <= 1'b1;
    end else if (do_release) begin
      state  <= IDLE;
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (do_grant)           cnt <= 4'd1;
    else if (do_release)         cnt <= '0;
    else if (state == GRANT)     cnt <= cnt + 4'd1;
  end
`endif

  assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed scoreboard bench for rr_burst_arbiter; burst-limit scenarios run when ARB_BURST_LIMIT_EN is defined.
module tb_rr_burst_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req3, req2, req1, req0;
  logic       gnt3, gnt2, gnt1, gnt0;
  logic       busy;
  logic [1:0] owner;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  rr_burst_arbiter #(.BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req3(req3), .req2(req2), .req1(req1), .req0(req0),
    .gnt3(gnt3), .gnt2(gnt2), .gnt1(gnt1), .gnt0(gnt0),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the expected registered result, then
  // check it 1ns after the edge that samples the stimulus.
  task automatic step(input logic r, input logic [3:0] req, input logic [3:0] eg,
                      input logic [1:0] eo, input string tag);
    exp_t e, got;
    logic [6:0] obs, want;
    rst = r;
    {req3, req2, req1, req0} = req;
    e.gnt = eg; e.busy = |eg; e.owner = eo; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = sb.pop_front();
    obs  = {gnt3, gnt2, gnt1, gnt0, busy, owner};
    want = {got.gnt, got.busy, got.owner};
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: gnt/busy/owner observed=%b required=%b", got.tag, obs, want);
    end
    total++;
    assert ($onehot0({gnt3, gnt2, gnt1, gnt0}) === 1'b1) else begin
      bad++;
      $error("FAIL %s_onehot: gnt observed=%b required=onehot0", got.tag, {gnt3, gnt2, gnt1, gnt0});
    end
  endtask

  initial begin
    rst = 1'b0;
    {req3, req2, req1, req0} = 4'b0;
    #1;
    // reset then single requester
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 2'd0, "reset");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, "single_rise");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, "single_hold1");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, "single_hold2");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, "single_drop");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, "idle_hold");

    // simultaneous requests, gapless handover
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "reset2");
    step(1'b1, 4'b0011, 4'b0001, 2'd0, "simul_first");
    step(1'b1, 4'b0011, 4'b0001, 2'd0, "simul_hold");
    step(1'b1, 4'b0010, 4'b0010, 2'd1, "simul_handover");
    step(1'b1, 4'b0000, 4'b0000, 2'd1, "simul_idle_owner");

    // reset mid-grant, ptr back to 0
    step(1'b1, 4'b0100, 4'b0100, 2'd2, "pre_reset_gnt2");
    step(1'b0, 4'b0100, 4'b0000, 2'd0, "reset_midgrant");
    step(1'b1, 4'b0101, 4'b0001, 2'd0, "post_reset_gnt0");
    step(1'b1, 4'b0100, 4'b0100, 2'd2, "post_reset_gnt2");
    step(1'b1, 4'b0000, 4'b0000, 2'd2, "idle_owner2");

    // ptr wrap 3 -> 0
    step(1'b1, 4'b1001, 4'b1000, 2'd3, "wrap_gnt3");
    step(1'b1, 4'b0001, 4'b0001, 2'd0, "wrap_gnt0");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, "wrap_idle");

`ifdef ARB_BURST_LIMIT_EN
    // fairness: each owner holds exactly 4 cycles, order 0,1,2,3,0
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "reset3");
    for (int i = 0; i < 20; i++) begin
      logic [1:0] o;
      o = 2'(i / 4);
      step(1'b1, 4'b1111, 4'b0001 << o, o, "fair");
    end
    step(1'b1, 4'b0000, 4'b0000, 2'd0, "fair_idle");
    // sole requester re-granted at the limit without a gap
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "reset4");
    for (int i = 0; i < 10; i++) step(1'b1, 4'b0100, 4'b0100, 2'd2, "sole_limit");
    step(1'b1, 4'b0000, 4'b0000, 2'd2, "sole_drop");
`else
    // no limit: req1 keeps ownership for 20 cycles despite req3
    for (int i = 0; i < 20; i++) step(1'b1, 4'b1010, 4'b0010, 2'd1, "nolimit_hold");
    step(1'b1, 4'b1000, 4'b1000, 2'd3, "nolimit_handover");
    step(1'b1, 4'b0000, 4'b0000, 2'd3, "nolimit_idle");
`endif

    total++;
    assert (sb.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: left=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
